spi_flash_cmd_seq: RTL and testbench
====================================

SPI_FLASH_CMD_SEQ -- requirements
Module: spi_flash_cmd_seq

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 16'd50000: maximum RDSR polls before timeout.
REQ-002 SHALL have parameter LEN_W, default 9: width of the data-byte count.
REQ-003 SHALL have port CLK_100M, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: operation request.
REQ-006 SHALL have port req_ready, output, 1: sequencer idle, accepting a request.
REQ-007 SHALL have port req_op, input, 2: 0=READ, 1=PAGE_PROGRAM, 2=SECTOR_ERASE, 3=READ_ID.
REQ-008 SHALL have port req_addr, input, 24: flash byte address.
REQ-009 SHALL have port req_len, input, LEN_W: data byte count for READ/PAGE_PROGRAM/READ_ID.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: sticky timeout flag, valid with done.
REQ-012 SHALL have port sh_start, output, 1: one-cycle pulse launching one SPI transaction on the shifter.
REQ-013 SHALL have port sh_opcode, output, 8: command byte.
REQ-014 SHALL have port sh_addr, output, 24: address bytes.
REQ-015 SHALL have port sh_addr_en, output, 1: transaction includes 3 address bytes.
REQ-016 SHALL have port sh_len, output, LEN_W: data bytes after opcode/address.
REQ-017 SHALL have port sh_done, input, 1: one-cycle pulse marking transaction end (S deasserted).
REQ-018 SHALL have port sh_rdata, input, 8: last byte received; valid when sh_done=1.

Function
REQ-019 SHALL implement states IDLE, WREN, WREN_W, CMD, CMD_W, POLL, POLL_W, FIN.
REQ-020 SHALL drive req_ready=1 only in IDLE; handshake completes when req_valid & req_ready on a rising edge.
REQ-021 SHALL latch req_op, req_addr, req_len on acceptance; later input changes have no effect.
REQ-022 SHALL go IDLE->WREN for PAGE_PROGRAM/SECTOR_ERASE, IDLE->CMD for READ/READ_ID.
REQ-023 SHALL pulse sh_start exactly one cycle on entry to WREN, CMD and POLL, then move to the matching _W state.
REQ-024 WREN SHALL present opcode 8'h06, sh_addr_en=0, sh_len=0.
REQ-025 CMD SHALL present: READ 8'h03/addr_en=1/len=req_len; PAGE_PROGRAM 8'h02/addr_en=1/len=req_len; SECTOR_ERASE 8'hD8/addr_en=1/len=0; READ_ID 8'h9F/addr_en=0/len=req_len.
REQ-026 POLL SHALL present opcode 8'h05, sh_addr_en=0, sh_len=1.
REQ-027 sh_opcode/sh_addr/sh_addr_en/sh_len SHALL stay stable from sh_start until sh_done.
REQ-028 _W states SHALL wait for sh_done, ignoring it in every other state; WREN_W->CMD; CMD_W->POLL for program/erase, ->FIN for READ/READ_ID.
REQ-029 POLL_W on sh_done SHALL go FIN if sh_rdata[0]=0 (WIP clear), else increment poll counter and return to POLL.
REQ-030 Poll counter SHALL clear on entry to CMD; when it reaches POLL_LIMIT with WIP still 1, SHALL set err=1 and go FIN.
REQ-031 FIN SHALL pulse done one cycle, then return to IDLE; minimum IDLE dwell 1 cycle.
REQ-032 err SHALL clear on the next accepted request; otherwise holds.
REQ-033 Latency SHALL be: request accept -> first sh_start 1 cycle; sh_done -> next sh_start 1 cycle; final sh_done -> done 1 cycle.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, req_ready=1, done=0, err=0, sh_start=0, sh_opcode=0, sh_addr=0, sh_addr_en=0, sh_len=0, poll counter=0.
REQ-035 rst mid-operation SHALL abort without further sh_start; an sh_done arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-036 READ addr 24'h000100 len 16 -> one sh_start, opcode 03, addr 000100, len 16; sh_done -> done 1 cycle later, err=0.
REQ-037 SECTOR_ERASE addr 24'h010000, sh_rdata 8'h03,8'h03,8'h00 on polls -> opcodes 06, D8, 05x3, done, err=0.
REQ-038 PAGE_PROGRAM with POLL_LIMIT=4 and sh_rdata fixed 8'h01 -> opcodes 06, 02, 05x4, done with err=1; next READ request clears err.
REQ-039 req_valid held high through operation with changing req_addr -> second request accepted only after done, latched values used.
REQ-040 rst asserted during POLL_W -> outputs at reset values same cycle; stray sh_done afterward causes no sh_start or done.

Source files
------------

// File: rtl/spi_flash_cmd_seq.sv
// SPI NOR flash command sequencer: turns READ / PAGE_PROGRAM / SECTOR_ERASE / READ_ID
// requests into WREN, command and RDSR-poll transactions on an external byte shifter.
module spi_flash_cmd_seq #(
    parameter logic [15:0] POLL_LIMIT = 16'd50000,
    parameter int          LEN_W      = 9
) (
    input  logic             CLK_100M,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             done,
    output logic             err,
    output logic             sh_start,
    output logic [7:0]       sh_opcode,
    output logic [23:0]      sh_addr,
    output logic             sh_addr_en,
    output logic [LEN_W-1:0] sh_len,
    input  logic             sh_done,
    input  logic [7:0]       sh_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WREN   = 3'd1;
    localparam logic [2:0] S_WREN_W = 3'd2;
    localparam logic [2:0] S_CMD    = 3'd3;
    localparam logic [2:0] S_CMD_W  = 3'd4;
    localparam logic [2:0] S_POLL   = 3'd5;
    localparam logic [2:0] S_POLL_W = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;
    localparam logic [1:0] OP_READ_ID = 2'd3;

    localparam logic [1:0] L_NONE = 2'd0;
    localparam logic [1:0] L_WREN = 2'd1;
    localparam logic [1:0] L_CMD  = 2'd2;
    localparam logic [1:0] L_POLL = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      poll_cnt_q, poll_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             sh_start_q, sh_start_d;
    logic [7:0]       sh_opcode_q, sh_opcode_d;
    logic [23:0]      sh_addr_q, sh_addr_d;
    logic             sh_addr_en_q, sh_addr_en_d;
    logic [LEN_W-1:0] sh_len_q, sh_len_d;
    logic [1:0]       launch;
    logic             poll_exhausted;

    // Only the WIP bit of the status register matters here.
    logic unused_status;
    assign unused_status = &{1'b0, sh_rdata[7:1]};

    function automatic logic needs_wel(input logic [1:0] op);
        return (op == OP_PROGRAM) || (op == OP_ERASE);
    endfunction

    function automatic logic [7:0] cmd_opcode(input logic [1:0] op);
        case (op)
            OP_READ:    return 8'h03;
            OP_PROGRAM: return 8'h02;
            OP_ERASE:   return 8'hD8;
            default:    return 8'h9F;
        endcase
    endfunction

    assign poll_exhausted = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_LIMIT};

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        len_d        = len_q;
        poll_cnt_d   = poll_cnt_q;
        err_d        = err_q;
        done_d       = 1'b0;
        sh_start_d   = 1'b0;
        sh_opcode_d  = sh_opcode_q;
        sh_addr_d    = sh_addr_q;
        sh_addr_en_d = sh_addr_en_q;
        sh_len_d     = sh_len_q;
        launch       = L_NONE;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    len_d  = req_len;
                    err_d  = 1'b0;
                    launch = needs_wel(req_op) ? L_WREN : L_CMD;
                end
            end
            S_WREN:   state_d = S_WREN_W;
            S_WREN_W: if (sh_done) launch = L_CMD;
            S_CMD:    state_d = S_CMD_W;
            S_CMD_W: begin
                if (sh_done) begin
                    if (needs_wel(op_q)) begin
                        launch = L_POLL;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_POLL:   state_d = S_POLL_W;
            S_POLL_W: begin
                if (sh_done) begin
                    if (!sh_rdata[0]) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (poll_exhausted) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        launch     = L_POLL;
                    end
                end
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Transaction fields are loaded together with sh_start and held until the next launch.
        case (launch)
            L_WREN: begin
                state_d      = S_WREN;
                sh_start_d   = 1'b1;
                sh_opcode_d  = 8'h06;
                sh_addr_d    = 24'h0;
                sh_addr_en_d = 1'b0;
                sh_len_d     = '0;
            end
            L_CMD: begin
                state_d      = S_CMD;
                sh_start_d   = 1'b1;
                sh_opcode_d  = cmd_opcode(op_d);
                sh_addr_d    = addr_d;
                sh_addr_en_d = (op_d != OP_READ_ID);
                sh_len_d     = (op_d == OP_ERASE) ? '0 : len_d;
                poll_cnt_d   = 16'd0;
            end
            L_POLL: begin
                state_d      = S_POLL;
                sh_start_d   = 1'b1;
                sh_opcode_d  = 8'h05;
                sh_addr_d    = 24'h0;
                sh_addr_en_d = 1'b0;
                sh_len_d     = LEN_W'(1);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK_100M or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_READ;
            addr_q       <= 24'h0;
            len_q        <= '0;
            poll_cnt_q   <= 16'd0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            sh_start_q   <= 1'b0;
            sh_opcode_q  <= 8'h0;
            sh_addr_q    <= 24'h0;
            sh_addr_en_q <= 1'b0;
            sh_len_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            poll_cnt_q   <= poll_cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
            sh_start_q   <= sh_start_d;
            sh_opcode_q  <= sh_opcode_d;
            sh_addr_q    <= sh_addr_d;
            sh_addr_en_q <= sh_addr_en_d;
            sh_len_q     <= sh_len_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign sh_start   = sh_start_q;
    assign sh_opcode  = sh_opcode_q;
    assign sh_addr    = sh_addr_q;
    assign sh_addr_en = sh_addr_en_q;
    assign sh_len     = sh_len_q;

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Directed bench for spi_flash_cmd_seq: a small shifter responder plus per-scenario tasks
// with hand-computed expected opcodes, fields, latencies and flags.
module tb_spi_flash_cmd_seq;

    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             done;
    logic             err;
    logic             sh_start;
    logic [7:0]       sh_opcode;
    logic [23:0]      sh_addr;
    logic             sh_addr_en;
    logic [LEN_W-1:0] sh_len;
    logic             sh_done;
    logic [7:0]       sh_rdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    spi_flash_cmd_seq #(.POLL_LIMIT(16'd4), .LEN_W(LEN_W)) dut (
        .CLK_100M   (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .done       (done),
        .err        (err),
        .sh_start   (sh_start),
        .sh_opcode  (sh_opcode),
        .sh_addr    (sh_addr),
        .sh_addr_en (sh_addr_en),
        .sh_len     (sh_len),
        .sh_done    (sh_done),
        .sh_rdata   (sh_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [LEN_W-1:0] len);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    // Shifter responder: waits (bounded) for sh_start, captures the fields, holds the
    // transaction for `hold` cycles watching field stability, then pulses sh_done.
    task automatic serve(input logic [7:0] rd, input int hold, output logic seen, output int lat,
                         output logic [7:0] op, output logic [23:0] ad, output logic ae,
                         output logic [LEN_W-1:0] ln, output logic stable);
        seen = 1'b0; lat = 0; stable = 1'b1;
        op = 8'h0; ad = 24'h0; ae = 1'b0; ln = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (sh_start) seen = 1'b1;
            else begin tick(); lat++; end
        end
        if (seen) begin
            op = sh_opcode; ad = sh_addr; ae = sh_addr_en; ln = sh_len;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (sh_start || sh_opcode != op || sh_addr != ad || sh_addr_en != ae || sh_len != ln)
                    stable = 1'b0;
            end
            sh_done  = 1'b1;
            sh_rdata = rd;
            tick();
            sh_done  = 1'b0;
            sh_rdata = 8'h00;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        tests++; if (done !== 1'b0 || err !== 1'b0 || sh_start !== 1'b0) begin
            failed++; $display("FAIL reset_flags: done=%b err=%b start=%b exp 0/0/0", done, err, sh_start); end
        tests++; if (sh_opcode !== 8'h0 || sh_addr !== 24'h0 || sh_addr_en !== 1'b0 || sh_len !== 9'd0) begin
            failed++; $display("FAIL reset_fields: op=%h addr=%h ae=%b len=%0d exp all 0", sh_opcode, sh_addr, sh_addr_en, sh_len); end
        rst = 1'b0;
        tick();
        tests++; if (req_ready !== 1'b1 || sh_start !== 1'b0) begin
            failed++; $display("FAIL reset_release: ready=%b start=%b exp 1/0", req_ready, sh_start); end
    endtask

    task automatic test_read();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        issue(2'd0, 24'h000100, 9'd16);
        tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL read_busy: ready=%b exp 0", req_ready); end
        serve(8'hA5, 3, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || lat != 0) begin failed++; $display("FAIL read_start: seen=%b lat=%0d exp 1/0", seen, lat); end
        tests++; if (op !== 8'h03 || ad !== 24'h000100 || ae !== 1'b1 || ln !== 9'd16) begin
            failed++; $display("FAIL read_fields: op=%h addr=%h ae=%b len=%0d exp 03/000100/1/16", op, ad, ae, ln); end
        tests++; if (!st) begin failed++; $display("FAIL read_stable: fields changed or extra start"); end
        tests++; if (done !== 1'b1 || err !== 1'b0) begin failed++; $display("FAIL read_done: done=%b err=%b exp 1/0", done, err); end
        tick();
        tests++; if (done !== 1'b0 || req_ready !== 1'b1 || sh_start !== 1'b0) begin
            failed++; $display("FAIL read_idle: done=%b ready=%b start=%b exp 0/1/0", done, req_ready, sh_start); end
    endtask

    task automatic test_read_id();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        issue(2'd3, 24'hABCDEF, 9'd3);
        serve(8'hEF, 1, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || op !== 8'h9F || ae !== 1'b0 || ln !== 9'd3 || !st) begin
            failed++; $display("FAIL rdid_fields: seen=%b op=%h ae=%b len=%0d st=%b exp 1/9f/0/3/1", seen, op, ae, ln, st); end
        tests++; if (done !== 1'b1) begin failed++; $display("FAIL rdid_done: got %b exp 1", done); end
        tick();
    endtask

    task automatic test_erase();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        logic [7:0] polls [3];
        polls[0] = 8'h03; polls[1] = 8'h03; polls[2] = 8'h00;
        issue(2'd2, 24'h010000, 9'd5);
        serve(8'h00, 2, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || lat != 0 || op !== 8'h06 || ae !== 1'b0 || ln !== 9'd0 || !st) begin
            failed++; $display("FAIL erase_wren: seen=%b lat=%0d op=%h ae=%b len=%0d exp 1/0/06/0/0", seen, lat, op, ae, ln); end
        serve(8'h00, 2, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || lat != 0 || op !== 8'hD8 || ad !== 24'h010000 || ae !== 1'b1 || ln !== 9'd0 || !st) begin
            failed++; $display("FAIL erase_cmd: seen=%b lat=%0d op=%h addr=%h ae=%b len=%0d exp 1/0/d8/010000/1/0", seen, lat, op, ad, ae, ln); end
        for (int i = 0; i < 3; i++) begin
            serve(polls[i], 1, seen, lat, op, ad, ae, ln, st);
            tests++; if (!seen || lat != 0 || op !== 8'h05 || ae !== 1'b0 || ln !== 9'd1 || !st) begin
                failed++; $display("FAIL erase_poll%0d: seen=%b lat=%0d op=%h ae=%b len=%0d exp 1/0/05/0/1", i, seen, lat, op, ae, ln); end
        end
        tests++; if (done !== 1'b1 || err !== 1'b0 || sh_start !== 1'b0) begin
            failed++; $display("FAIL erase_done: done=%b err=%b start=%b exp 1/0/0", done, err, sh_start); end
        tick();
    endtask

    task automatic test_program_timeout();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        int polls_seen;
        issue(2'd1, 24'h123456, 9'd256);
        serve(8'h00, 1, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || op !== 8'h06) begin failed++; $display("FAIL prog_wren: seen=%b op=%h exp 1/06", seen, op); end
        serve(8'h00, 4, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || op !== 8'h02 || ad !== 24'h123456 || ae !== 1'b1 || ln !== 9'd256 || !st) begin
            failed++; $display("FAIL prog_cmd: seen=%b op=%h addr=%h ae=%b len=%0d exp 1/02/123456/1/256", seen, op, ad, ae, ln); end
        polls_seen = 0;
        for (int i = 0; i < 4; i++) begin
            serve(8'h01, 1, seen, lat, op, ad, ae, ln, st);
            if (seen && op == 8'h05 && lat == 0) polls_seen++;
        end
        tests++; if (polls_seen != 4) begin failed++; $display("FAIL prog_polls: got %0d exp 4", polls_seen); end
        tests++; if (done !== 1'b1 || err !== 1'b1) begin failed++; $display("FAIL prog_timeout: done=%b err=%b exp 1/1", done, err); end
        tick();
        tests++; if (err !== 1'b1 || done !== 1'b0 || sh_start !== 1'b0) begin
            failed++; $display("FAIL prog_sticky: err=%b done=%b start=%b exp 1/0/0", err, done, sh_start); end
        issue(2'd0, 24'h000200, 9'd1);
        tests++; if (err !== 1'b0) begin failed++; $display("FAIL err_clear: got %b exp 0", err); end
        serve(8'h00, 1, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || op !== 8'h03 || done !== 1'b1 || err !== 1'b0) begin
            failed++; $display("FAIL after_err_read: seen=%b op=%h done=%b err=%b exp 1/03/1/0", seen, op, done, err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        req_valid = 1'b1; req_op = 2'd0; req_addr = 24'h00AAAA; req_len = 9'd4;
        tick();
        req_addr = 24'h00BBBB; req_len = 9'd7;
        serve(8'h00, 2, seen, lat, op, ad, ae, ln, st);
        tests++; if (!seen || ad !== 24'h00AAAA || ln !== 9'd4 || !st) begin
            failed++; $display("FAIL b2b_first: seen=%b addr=%h len=%0d st=%b exp 1/00aaaa/4/1", seen, ad, ln, st); end
        tests++; if (done !== 1'b1 || req_ready !== 1'b0) begin
            failed++; $display("FAIL b2b_done: done=%b ready=%b exp 1/0", done, req_ready); end
        tick();
        tests++; if (req_ready !== 1'b1 || sh_start !== 1'b0) begin
            failed++; $display("FAIL b2b_dwell: ready=%b start=%b exp 1/0", req_ready, sh_start); end
        serve(8'h00, 1, seen, lat, op, ad, ae, ln, st);
        req_valid = 1'b0;
        tests++; if (!seen || lat != 1 || ad !== 24'h00BBBB || ln !== 9'd7) begin
            failed++; $display("FAIL b2b_second: seen=%b lat=%0d addr=%h len=%0d exp 1/1/00bbbb/7", seen, lat, ad, ln); end
        tests++; if (done !== 1'b1) begin failed++; $display("FAIL b2b_done2: got %b exp 1", done); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic seen, ae, st; int lat; logic [7:0] op; logic [23:0] ad; logic [LEN_W-1:0] ln;
        logic stray;
        issue(2'd2, 24'h020000, 9'd0);
        serve(8'h00, 1, seen, lat, op, ad, ae, ln, st);
        serve(8'h00, 1, seen, lat, op, ad, ae, ln, st);
        tick();
        tests++; if (sh_opcode !== 8'h05 || sh_start !== 1'b0) begin
            failed++; $display("FAIL abort_in_poll: op=%h start=%b exp 05/0", sh_opcode, sh_start); end
        rst = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || sh_start !== 1'b0 ||
                     sh_opcode !== 8'h0 || sh_addr !== 24'h0 || sh_addr_en !== 1'b0 || sh_len !== 9'd0) begin
            failed++; $display("FAIL abort_async: ready=%b done=%b err=%b start=%b op=%h addr=%h ae=%b len=%0d exp reset values",
                               req_ready, done, err, sh_start, sh_opcode, sh_addr, sh_addr_en, sh_len); end
        tick();
        rst = 1'b0;
        tick();
        sh_done = 1'b1; sh_rdata = 8'h01;
        tick();
        sh_done = 1'b0; sh_rdata = 8'h00;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (sh_start || done || !req_ready) stray = 1'b1;
            tick();
        end
        tests++; if (stray) begin failed++; $display("FAIL abort_stray_done: unexpected start/done or busy after reset"); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 24'h0; req_len = '0;
        sh_done = 1'b0; sh_rdata = 8'h00;
        test_reset();
        test_read();
        test_read_id();
        test_erase();
        test_program_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
